// File: rtl/sram_bank_pkg.sv
// Shared types and helpers for the sram_bank memory tile.
// Lane parity is even parity: one bit per byte, equal to the XOR of that byte.
package sram_bank_pkg;

  localparam int BYTE_W     = 8;
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / BYTE_W;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  // Callers zero-extend their word to MAX_DATA_W; unused upper lanes come out 0.
  function automatic logic [MAX_BE_W-1:0] lane_parity(input logic [MAX_DATA_W-1:0] word);
    logic [MAX_BE_W-1:0] par;
    par = '0;
    for (int i = 0; i < MAX_BE_W; i++) begin
      par[i] = ^word[i*BYTE_W +: BYTE_W];
    end
    return par;
  endfunction

endpackage

// File: rtl/sram_bank_array.sv
// Storage for sram_bank: byte-lane write, combinational read at the same address.
// With SRAM_BANK_PARITY_EN defined, one parity bit per lane is stored alongside the data.
module sram_bank_array
  import sram_bank_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W/BYTE_W-1:0] be,
  input  logic [DATA_W-1:0]        wdata,
`ifdef SRAM_BANK_PARITY_EN
  input  logic [DATA_W/BYTE_W-1:0] wpar,
  output logic [DATA_W/BYTE_W-1:0] rpar,
`endif
  output logic [DATA_W-1:0]        rdata
);

  localparam int BE_W = DATA_W / BYTE_W;

  logic [DATA_W-1:0] mem_data [DEPTH];

  // NOTE: the array has no reset branch; the top's init sequencer zero-fills it.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem_data[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign rdata = mem_data[addr];

`ifdef SRAM_BANK_PARITY_EN
  logic [BE_W-1:0] mem_par [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem_par[addr][i] <= wpar[i];
      end
    end
  end

  assign rpar = mem_par[addr];
`endif

endmodule

// File: rtl/sram_bank.sv
// Single-port SRAM bank: zero-fill init sequencer, valid/ready requests, 1-cycle read response.
// Optional lane parity storage and checking is enabled by defining SRAM_BANK_PARITY_EN.
module sram_bank
  import sram_bank_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W/BYTE_W-1:0] req_be,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_perr,
  input  logic                     perr_inj,
  output logic                     init_busy
);

  localparam int                BE_W      = DATA_W / BYTE_W;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_addr;
  logic              in_range, wr_fire, rd_fire, rd_perr;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [BE_W-1:0]   arr_be;
  logic [DATA_W-1:0] arr_wdata, arr_rdata;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= INIT;
      init_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_addr <= init_addr + 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (state == INIT && init_addr == LAST_ADDR) state_nxt = READY;
  end

  assign req_ready = (state == READY);
  assign init_busy = (state == INIT);

  assign in_range = {1'b0, req_addr} < DEPTH_L;
  assign wr_fire  = req_ready && req_valid && req_we && in_range;
  assign rd_fire  = req_ready && req_valid && !req_we;

  // Init owns the array port until READY; afterwards it follows the request.
  always_comb begin
    arr_we    = 1'b1;
    arr_addr  = init_addr;
    arr_be    = '1;
    arr_wdata = '0;
    if (state == READY) begin
      arr_we    = wr_fire;
      arr_addr  = req_addr;
      arr_be    = req_be;
      arr_wdata = req_wdata;
    end
  end

`ifdef SRAM_BANK_PARITY_EN
  logic [BE_W-1:0] arr_wpar, arr_rpar;

  assign arr_wpar = (state == READY)
                  ? (BE_W'(lane_parity(MAX_DATA_W'(req_wdata))) ^ {BE_W{perr_inj}})
                  : '0;
  assign rd_perr  = in_range && (lane_parity(MAX_DATA_W'(arr_rdata)) != MAX_BE_W'(arr_rpar));
`else
  logic unused_perr_inj;

  assign unused_perr_inj = perr_inj;
  assign rd_perr         = 1'b0;
`endif

  sram_bank_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .be    (arr_be),
    .wdata (arr_wdata),
`ifdef SRAM_BANK_PARITY_EN
    .wpar  (arr_wpar),
    .rpar  (arr_rpar),
`endif
    .rdata (arr_rdata)
  );

  // Response data holds between reads; out-of-range reads answer with zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_perr  <= 1'b0;
    end else begin
      rsp_valid <= rd_fire;
      if (rd_fire) begin
        rsp_rdata <= in_range ? arr_rdata : '0;
        rsp_perr  <= rd_perr;
      end
    end
  end

endmodule

// File: tb/tb_sram_bank.sv
// Self-checking bench for sram_bank: a DEPTH=32 and a DEPTH=20 instance share one stimulus
// stream and are compared against a word-array reference model with per-lane corruption flags.
module tb_sram_bank;

`ifdef SRAM_BANK_PARITY_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [1:0]  req_be = '0;
  logic [15:0] req_wdata = '0;
  logic        perr_inj = 1'b0;

  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_rdata [2];
  logic        rsp_perr  [2];
  logic        init_busy [2];

  always #5 clk = ~clk;

  sram_bank #(.DATA_W(16), .ADDR_W(5), .DEPTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_perr(rsp_perr[0]),
    .perr_inj(perr_inj), .init_busy(init_busy[0])
  );

  sram_bank #(.DATA_W(16), .ADDR_W(5), .DEPTH(20)) u_dut20 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_perr(rsp_perr[1]),
    .perr_inj(perr_inj), .init_busy(init_busy[1])
  );

  // Reference model state, one slot per instance.
  logic [15:0] m_mem  [2][32];
  logic [1:0]  m_bad  [2][32];
  int          m_init_left [2];
  logic        m_valid [2];
  logic [15:0] m_rdata [2];
  logic        m_perr  [2];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic        inj;
    logic        exp_valid;
    logic [15:0] exp_rdata;
    logic        exp_perr;
  } vec_t;

  vec_t tv [17];

  function automatic int depth_of(input int k);
    return (k == 0) ? 32 : 20;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_init_left[k] = depth_of(k);
    m_valid[k] = 1'b0;
    m_rdata[k] = '0;
    m_perr[k]  = 1'b0;
    for (int a = 0; a < 32; a++) begin
      m_mem[k][a] = '0;
      m_bad[k][a] = '0;
    end
  endtask

  // One clock: drive at negedge, check ready before the edge, check responses after it.
  task automatic step(input logic r, input logic v, input logic we, input logic [4:0] a,
                      input logic [1:0] be, input logic [15:0] d, input logic inj);
    logic rdy [2];
    rst = r; req_valid = v; req_we = we; req_addr = a; req_be = be; req_wdata = d; perr_inj = inj;
    for (int k = 0; k < 2; k++) begin
      rdy[k] = (m_init_left[k] == 0);
      check($sformatf("ready[%0d]", k), req_ready[k], rdy[k]);
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        model_reset(k);
      end else if (!rdy[k]) begin
        m_init_left[k]--;
        m_valid[k] = 1'b0;
      end else begin
        m_valid[k] = v && !we;
        if (v && we && int'(a) < depth_of(k)) begin
          for (int l = 0; l < 2; l++) begin
            if (be[l]) begin
              m_mem[k][a][l*8 +: 8] = d[l*8 +: 8];
              m_bad[k][a][l]        = inj & PAR_ON;
            end
          end
        end
        if (v && !we) begin
          m_rdata[k] = (int'(a) < depth_of(k)) ? m_mem[k][a] : 16'h0000;
          m_perr[k]  = (int'(a) < depth_of(k)) && (m_bad[k][a] != 2'b00);
        end
      end
      check($sformatf("rsp_valid[%0d]", k), rsp_valid[k], m_valid[k]);
      check($sformatf("rsp_rdata[%0d]", k), rsp_rdata[k], m_rdata[k]);
      check($sformatf("init_busy[%0d]", k), init_busy[k], m_init_left[k] != 0);
      if (m_valid[k]) check($sformatf("rsp_perr[%0d]", k), rsp_perr[k], m_perr[k]);
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 16'h0000, 1'b0);
  endtask

  task automatic rd(input logic [4:0] a);
    step(1'b1, 1'b1, 1'b0, a, 2'b00, 16'h0000, 1'b0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [1:0] be, input logic [15:0] d);
    step(1'b1, 1'b1, 1'b1, a, be, d, 1'b0);
  endtask

  // Counts cycles with req_ready low from reset release, bounded at 40 cycles.
  task automatic count_init(input string tag);
    int lo [2];
    lo[0] = 0;
    lo[1] = 0;
    for (int c = 0; c < 40; c++) begin
      for (int k = 0; k < 2; k++) if (!req_ready[k]) lo[k]++;
      idle();
    end
    check($sformatf("%s init cycles d32", tag), lo[0], 32);
    check($sformatf("%s init cycles d20", tag), lo[1], 20);
  endtask

  initial begin
    int pulses;

    tv[0]  = '{1'b1, 5'd3,  2'b11, 16'hAAAA, 1'b0, 1'b0, 16'h0000, 1'b0};
    tv[1]  = '{1'b1, 5'd3,  2'b01, 16'h5555, 1'b0, 1'b0, 16'h0000, 1'b0};
    tv[2]  = '{1'b0, 5'd3,  2'b00, 16'h0000, 1'b0, 1'b1, 16'hAA55, 1'b0};
    tv[3]  = '{1'b1, 5'd7,  2'b11, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0};
    tv[4]  = '{1'b0, 5'd7,  2'b00, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0};
    tv[5]  = '{1'b1, 5'd9,  2'b00, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0};
    tv[6]  = '{1'b0, 5'd9,  2'b00, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0};
    tv[7]  = '{1'b1, 5'd10, 2'b10, 16'hABCD, 1'b0, 1'b0, 16'h0000, 1'b0};
    tv[8]  = '{1'b0, 5'd10, 2'b00, 16'h0000, 1'b0, 1'b1, 16'hAB00, 1'b0};
    tv[9]  = '{1'b1, 5'd31, 2'b11, 16'hCAFE, 1'b0, 1'b0, 16'h0000, 1'b0};
    tv[10] = '{1'b0, 5'd31, 2'b00, 16'h0000, 1'b0, 1'b1, 16'hCAFE, 1'b0};
    tv[11] = '{1'b1, 5'd5,  2'b11, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 1'b0};
    tv[12] = '{1'b0, 5'd5,  2'b00, 16'h0000, 1'b0, 1'b1, 16'hBEEF, PAR_ON};
    tv[13] = '{1'b1, 5'd5,  2'b11, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0};
    tv[14] = '{1'b0, 5'd5,  2'b00, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b0};
    tv[15] = '{1'b1, 5'd5,  2'b01, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    tv[16] = '{1'b0, 5'd5,  2'b00, 16'h0000, 1'b0, 1'b1, 16'hBE00, PAR_ON};

    // Reset state.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      check($sformatf("reset rsp_valid[%0d]", k), rsp_valid[k], 1'b0);
      check($sformatf("reset rsp_rdata[%0d]", k), rsp_rdata[k], 16'h0000);
      check($sformatf("reset rsp_perr[%0d]", k), rsp_perr[k], 1'b0);
      check($sformatf("reset init_busy[%0d]", k), init_busy[k], 1'b1);
      check($sformatf("reset req_ready[%0d]", k), req_ready[k], 1'b0);
    end

    // Init length, then every word reads back as zero.
    count_init("first");
    for (int a = 0; a < 32; a++) rd(5'(a));

    // Directed vectors.
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b1, tv[i].we, tv[i].addr, tv[i].be, tv[i].wdata, tv[i].inj);
      check($sformatf("vec%0d valid", i), rsp_valid[0], tv[i].exp_valid);
      if (tv[i].exp_valid) begin
        check($sformatf("vec%0d rdata", i), rsp_rdata[0], tv[i].exp_rdata);
        check($sformatf("vec%0d perr", i), rsp_perr[0], tv[i].exp_perr);
      end
    end

    // Write then immediate read, followed by 8 back-to-back reads.
    wr(5'd7, 2'b11, 16'h1234);
    rd(5'd7);
    check("raw rdata", rsp_rdata[0], 16'h1234);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      rd(5'd7);
      if (rsp_valid[0]) pulses++;
    end
    check("b2b pulses", pulses, 8);

    // Out-of-range on the DEPTH=20 instance.
    wr(5'd19, 2'b11, 16'h1357);
    wr(5'd25, 2'b11, 16'hFFFF);
    rd(5'd25);
    check("oor rdata", rsp_rdata[1], 16'h0000);
    check("oor valid", rsp_valid[1], 1'b1);
    rd(5'd19);
    check("addr19 rdata", rsp_rdata[1], 16'h1357);

    // Reset arriving with a read on the port discards the response.
    rd(5'd3);
    step(1'b0, 1'b1, 1'b0, 5'd3, 2'b00, 16'h0000, 1'b0);
    check("rst read valid", rsp_valid[0], 1'b0);

    // Reset again at init cycle 10; init must run its full length.
    for (int i = 0; i < 10; i++) idle();
    step(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 16'h0000, 1'b0);
    count_init("mid");

    // Randomized traffic with rare resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 16'($urandom),
           ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
